// File: rtl/load_store_unit.sv
// load_store_unit
//   Single-port load/store unit in front of a private word-organised data
//   memory. Handles one request at a time through IDLE -> ACCESS -> RESP.
//   RV32 byte/half/word loads (sign or zero extended) and byte-lane stores.
//
//   Optional feature macro: LSU_MISALIGN_TRAP_EN
//     defined   : misaligned half/word accesses return rsp_err and do nothing
//     undefined : low address bits are forced to natural alignment
//
// Ports
//   clk, reset                  clock (rising edge), async active-high reset
//   req_valid / req_ready       request handshake (ready only in IDLE)
//   req_we                      1 = store, 0 = load
//   req_funct3                  RV32 width/sign code
//   req_addr                    byte address
//   req_wdata                   store data, LSB-justified
//   rsp_valid / rsp_ready       response handshake (held in RESP)
//   rsp_rdata                   load result, 0 for stores and errors
//   rsp_err                     illegal funct3 or trapped misalignment
//   busy                        state is not IDLE
module load_store_unit #(
    parameter int DM_ADDRESS = 9,
    parameter int DATA_W     = 32,
    parameter int LATENCY    = 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_we,
    input  logic [2:0]            req_funct3,
    input  logic [DM_ADDRESS-1:0] req_addr,
    input  logic [DATA_W-1:0]     req_wdata,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [DATA_W-1:0]     rsp_rdata,
    output logic                  rsp_err,
    output logic                  busy
);

    localparam int         DEPTH  = 1 << (DM_ADDRESS - 2);
    localparam logic [2:0] LAT_M1 = 3'(LATENCY - 1);

    typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

    state_t                state_q, state_d;
    logic [2:0]            cnt_q, cnt_d;
    logic                  we_q, we_d;
    logic [2:0]            f3_q, f3_d;
    logic [DM_ADDRESS-1:0] addr_q, addr_d;
    logic [DATA_W-1:0]     wdata_q, wdata_d;
    logic [DATA_W-1:0]     rdata_q, rdata_d;
    logic                  err_q, err_d;

    logic [DATA_W-1:0]     mem [0:DEPTH-1];

    logic [1:0]            lane;
    logic [DM_ADDRESS-3:0] widx;
    logic                  legal, misal, acc_err, commit;
    logic [3:0]            be;
    logic [DATA_W-1:0]     wword, mword, shifted, ld_val;

    // Access decode, all from the captured request.
    always_comb begin
        lane  = addr_q[1:0];
        widx  = addr_q[DM_ADDRESS-1:2];
        legal = we_q ? (f3_q inside {3'b000, 3'b001, 3'b010})
                     : (f3_q inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101});
        misal = 1'b0;
`ifdef LSU_MISALIGN_TRAP_EN
        misal = ((f3_q[1:0] == 2'b01) && addr_q[0]) ||
                ((f3_q[1:0] == 2'b10) && (addr_q[1:0] != 2'b00));
`else
        // Silently align: halves drop addr[0], words drop addr[1:0].
        if (f3_q[1:0] == 2'b01)      lane[0] = 1'b0;
        else if (f3_q[1:0] == 2'b10) lane    = 2'b00;
`endif
        acc_err = !legal || misal;

        mword   = mem[widx];
        shifted = mword >> {lane, 3'b000};
        case (f3_q)
            3'b000:  ld_val = {{24{shifted[7]}},  shifted[7:0]};
            3'b001:  ld_val = {{16{shifted[15]}}, shifted[15:0]};
            3'b100:  ld_val = {24'b0, shifted[7:0]};
            3'b101:  ld_val = {16'b0, shifted[15:0]};
            default: ld_val = mword;
        endcase

        // Store data is replicated across lanes so the enables pick the slot.
        case (f3_q[1:0])
            2'b00:   begin be = 4'b0001 << lane; wword = {4{wdata_q[7:0]}};  end
            2'b01:   begin be = 4'b0011 << lane; wword = {2{wdata_q[15:0]}}; end
            default: begin be = 4'b1111;         wword = wdata_q;            end
        endcase

        commit = (state_q == ACCESS) && (cnt_q == 3'd0);
    end

    // Memory is deliberately not reset. commit is low whenever reset is
    // asserted because the state register resets asynchronously.
    always_ff @(posedge clk) begin
        if (commit && we_q && !acc_err) begin
            for (int b = 0; b < 4; b++) begin
                if (be[b]) mem[widx][8*b +: 8] <= wword[8*b +: 8];
            end
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        we_d    = we_q;
        f3_d    = f3_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        err_d   = err_q;
        case (state_q)
            IDLE: begin
                if (req_valid) begin
                    state_d = ACCESS;
                    cnt_d   = LAT_M1;
                    we_d    = req_we;
                    f3_d    = req_funct3;
                    addr_d  = req_addr;
                    wdata_d = req_wdata;
                end
            end
            ACCESS: begin
                if (cnt_q == 3'd0) begin
                    state_d = RESP;
                    err_d   = acc_err;
                    rdata_d = (acc_err || we_q) ? '0 : ld_val;
                end else begin
                    cnt_d = cnt_q - 3'd1;
                end
            end
            RESP: begin
                if (rsp_ready) begin
                    state_d = IDLE;
                    rdata_d = '0;
                    err_d   = 1'b0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= 3'd0;
            we_q    <= 1'b0;
            f3_q    <= 3'b000;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            we_q    <= we_d;
            f3_q    <= f3_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
        end
    end

    assign req_ready = (state_q == IDLE);
    assign busy      = (state_q != IDLE);
    assign rsp_valid = (state_q == RESP);
    assign rsp_rdata = rdata_q;
    assign rsp_err   = err_q;

endmodule
